sim_stim_ctrl: RTL and testbench
================================

// Module: sim_stim_ctrl
// PURPOSE
//  Parametrised stimulus/watchdog controller between the simulation top and the core under test.
//  Sequences the core reset and drives N_IRQ programmable interrupt channels (periodic, pulse or level+ack).
//  Ends the run on core trap or cycle timeout. Replaces fixed-delay reset and tied-off interrupt lines.
// PARAMETERS
//  N_IRQ          4      interrupt channels; ch0..3 = debug, mtip, msip, meip
//  RESET_CYCLES   10     clock cycles core_reset is held after controller reset release (>=1)
//  TIMEOUT_CYCLES 10000  RUN cycles before timeout; 0 = no timeout
//  PERIOD_W       16     width of each channel period register/counter
// PORTS
//  clock         in   1              single clock; all logic rising-edge
//  reset         in   1              asynchronous assert, active-low (0 = reset)
//  cfg_we        in   1              config write strobe
//  cfg_sel       in   clog2(N_IRQ)   channel written; values >= N_IRQ ignored
//  cfg_period    in   PERIOD_W       period in cycles; 0 = channel disabled
//  cfg_level     in   1              1 = level mode (hold until ack), 0 = 1-cycle pulse
//  irq_ack       in   N_IRQ          per-channel acknowledge (level mode only)
//  trap          in   1              core trap indication
//  core_reset    out  1              active-high reset to core
//  irq           out  N_IRQ          interrupt lines to core
//  done          out  1              run finished (sticky)
//  status        out  2              00 running, 01 trap, 10 timeout, 11 reserved
//  cycle_count   out  32             RUN cycles elapsed, saturates at 2^32-1
// BEHAVIOUR
//  Reset (reset=0): state=HOLD, core_reset=1, irq=0, done=0, status=00, cycle_count=0,
//   all periods=0, all level flags=0, channel counters=0, hold counter=0.
//  FSM HOLD -> RUN -> DONE; DONE exits only via reset.
//  HOLD: hold counter increments; at RESET_CYCLES-1 go RUN; core_reset falls on the RUN entry edge
//   (core_reset=1 for exactly RESET_CYCLES cycles after reset release). irq=0 in HOLD.
//  RUN: cycle_count +1/cycle. Channel i with period P>0: counter counts 0..P-1 and wraps; asserts
//   at wrap (first fire P cycles after RUN entry, then every P).
//   Pulse mode: irq[i]=1 for one cycle per fire.
//   Level mode: irq[i] set on fire, cleared the cycle after irq_ack[i]=1; fire+ack same cycle -> stays set.
//   irq_ack ignored in pulse mode or while irq[i]=0.
//  Config writes accepted in any state; take effect next cycle; write clears the channel counter
//   and irq[i]. Writing period 0 disables and clears the channel.
//  RUN -> DONE: trap=1 -> status=01; else if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1
//   -> status=10. Trap and timeout same cycle -> trap wins (01).
//  DONE: done=1, irq=0, core_reset=1 (core parked), cycle_count frozen. trap during HOLD ignored.
//  Reset mid-run: immediate async return to reset values; new HOLD sequence after release.
// CONFIGURATION
//  SIM_STIM_TRAPLOG_EN defined: extra outputs trap_count[15:0] (trap rising edges in RUN+DONE,
//   saturating, incl. the terminating trap) and trap_cycle[31:0] (cycle_count at first trap,
//   captured once). Both reset to 0.
//  Not defined: ports absent, no extra flops; all other behaviour identical.
// TESTING
//  Defaults, no cfg, trap=0: core_reset high exactly 10 cycles; done=1, status=10 at RUN cycle 10000.
//  cfg ch1 period=5 pulse: irq[1] 1-cycle pulses at RUN cycles 5,10,15; other channels stay 0.
//  cfg ch3 period=4 level, ack at RUN cycle 7: irq[3] high cycles 4..7, low 8..11, high again at 12.
//  trap=1 at RUN cycle 300: next edge done=1, status=01, cycle_count=300, irq=0, core_reset=1.
//  trap and timeout in same cycle (TIMEOUT_CYCLES=50, trap at cycle 49): status=01.
//  reset=0 mid-RUN with irq active: all outputs to reset values asynchronously; HOLD repeats 10 cycles.

Source files
------------

// File: rtl/sim_stim_ctrl.sv
// sim_stim_ctrl: core reset sequencer, programmable interrupt generator and run watchdog.
// Optional trap logging ports (trap_count, trap_cycle) exist only when SIM_STIM_TRAPLOG_EN is defined.
module sim_stim_ctrl #(
    parameter int unsigned N_IRQ          = 4,
    parameter int unsigned RESET_CYCLES   = 10,
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned PERIOD_W       = 16,
    localparam int unsigned SEL_W         = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_level,
    input  logic [N_IRQ-1:0]    irq_ack,
    input  logic                trap,
    output logic                core_reset,
    output logic [N_IRQ-1:0]    irq,
    output logic                done,
    output logic [1:0]          status,
    output logic [31:0]         cycle_count
`ifdef SIM_STIM_TRAPLOG_EN
    ,
    output logic [15:0]         trap_count,
    output logic [31:0]         trap_cycle
`endif
);

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;

    state_t                r_state;
    logic                  r_core_reset;
    logic                  r_done;
    logic [N_IRQ-1:0]      r_irq;
    logic [1:0]            r_status;
    logic [31:0]           r_cycle_count;
    logic [31:0]           r_hold_cnt;
    logic [PERIOD_W-1:0]   r_period [N_IRQ];
    logic [PERIOD_W-1:0]   r_cnt    [N_IRQ];
    logic [N_IRQ-1:0]      r_level;

    logic [N_IRQ-1:0]      w_wr;
    logic                  w_timeout;

    always_comb begin
        w_wr = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (cfg_we && (32'(cfg_sel) == i)) w_wr[i] = 1'b1;
        end
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cycle_count == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_HOLD;
            r_core_reset  <= 1'b1;
            r_done        <= 1'b0;
            r_irq         <= '0;
            r_status      <= 2'b00;
            r_cycle_count <= '0;
            r_hold_cnt    <= '0;
            r_level       <= '0;
            for (int unsigned i = 0; i < N_IRQ; i++) begin
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            unique case (r_state)
                S_HOLD: begin
                    r_irq <= '0;
                    if (r_hold_cnt == 32'(RESET_CYCLES - 1)) begin
                        r_state      <= S_RUN;
                        r_core_reset <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    if (trap || w_timeout) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b1;
                        r_irq        <= '0;
                        r_status     <= trap ? 2'b01 : 2'b10;
                    end else begin
                        if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
                        // A pending level interrupt freezes its counter; the period restarts after the ack.
                        for (int unsigned i = 0; i < N_IRQ; i++) begin
                            if (r_period[i] == '0) begin
                                r_irq[i] <= 1'b0;
                            end else if (r_level[i] && r_irq[i]) begin
                                if (irq_ack[i]) r_irq[i] <= 1'b0;
                            end else if (r_cnt[i] == r_period[i] - PERIOD_W'(1)) begin
                                r_cnt[i] <= '0;
                                r_irq[i] <= 1'b1;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + PERIOD_W'(1);
                                r_irq[i] <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_irq <= '0;
                end
            endcase

            for (int unsigned i = 0; i < N_IRQ; i++) begin
                if (w_wr[i]) begin
                    r_period[i] <= cfg_period;
                    r_level[i]  <= cfg_level;
                    r_cnt[i]    <= '0;
                    r_irq[i]    <= 1'b0;
                end
            end
        end
    end

    assign core_reset  = r_core_reset;
    assign irq         = r_irq;
    assign done        = r_done;
    assign status      = r_status;
    assign cycle_count = r_cycle_count;

`ifdef SIM_STIM_TRAPLOG_EN
    logic        r_trap_d;
    logic        r_trap_seen;
    logic [15:0] r_trap_count;
    logic [31:0] r_trap_cycle;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_trap_d     <= 1'b0;
            r_trap_seen  <= 1'b0;
            r_trap_count <= '0;
            r_trap_cycle <= '0;
        end else begin
            r_trap_d <= trap;
            if ((r_state != S_HOLD) && trap && !r_trap_d && (r_trap_count != '1))
                r_trap_count <= r_trap_count + 16'd1;
            if ((r_state == S_RUN) && trap && !r_trap_seen) begin
                r_trap_seen  <= 1'b1;
                r_trap_cycle <= r_cycle_count;
            end
        end
    end

    assign trap_count = r_trap_count;
    assign trap_cycle = r_trap_cycle;
`endif

endmodule

// File: tb/tb_sim_stim_ctrl.sv
// Self-checking bench for sim_stim_ctrl: reset sequencing, interrupt channels, trap/timeout termination.
module tb_sim_stim_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, reset_b;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_period;
    logic        cfg_level;
    logic [3:0]  irq_ack;
    logic        trap, trap_b;

    logic        core_reset, core_reset_b;
    logic [3:0]  irq, irq_b;
    logic        done, done_b;
    logic [1:0]  status, status_b;
    logic [31:0] cycle_count, cycle_count_b;

    int checks = 0;
    int errors = 0;
    int cur_c  = 0;

    // Reference model: per-channel period, mode, restart cycle, pending flag, next level fire cycle
    int m_per  [4];
    bit m_lvl  [4];
    int m_base [4];
    bit m_pend [4];
    int m_next [4];

    sim_stim_ctrl dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_period(cfg_period), .cfg_level(cfg_level), .irq_ack(irq_ack), .trap(trap),
        .core_reset(core_reset), .irq(irq), .done(done), .status(status),
        .cycle_count(cycle_count)
    );

    sim_stim_ctrl #(.TIMEOUT_CYCLES(50)) dut_b (
        .clock(clock), .reset(reset_b), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_period(cfg_period), .cfg_level(cfg_level), .irq_ack(irq_ack), .trap(trap_b),
        .core_reset(core_reset_b), .irq(irq_b), .done(done_b), .status(status_b),
        .cycle_count(cycle_count_b)
    );

    task automatic model_cfg(input int ch, input int p, input bit l, input int eff);
        m_per[ch]  = p;
        m_lvl[ch]  = l;
        m_base[ch] = eff;
        m_pend[ch] = 1'b0;
        m_next[ch] = eff + p;
    endtask

    task automatic model_expect(input int c, output logic [3:0] exp);
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_per[i] != 0) begin
                if (!m_lvl[i]) begin
                    if (c > m_base[i] && ((c - m_base[i]) % m_per[i]) == 0) exp[i] = 1'b1;
                end else begin
                    if (!m_pend[i] && c == m_next[i]) m_pend[i] = 1'b1;
                    exp[i] = m_pend[i];
                end
            end
        end
    endtask

    task automatic model_ack(input int c, input logic [3:0] ack);
        for (int i = 0; i < 4; i++) begin
            if (m_per[i] != 0 && m_lvl[i] && m_pend[i] && ack[i]) begin
                m_pend[i] = 1'b0;
                m_next[i] = c + 1 + m_per[i];
            end
        end
    endtask

    task automatic start_run(input logic [3:0][15:0] per, input logic [3:0] lvl);
        int k;
        reset = 1'b0; trap = 1'b0; irq_ack = '0; cfg_we = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        k = 0;
        for (int ch = 0; ch < 4; ch++) begin
            cfg_we = 1'b1; cfg_sel = 2'(ch); cfg_period = per[ch]; cfg_level = lvl[ch];
            @(posedge clock); #1; k++;
            model_cfg(ch, int'(per[ch]), lvl[ch], 0);
        end
        cfg_we = 1'b0;
        while (core_reset !== 1'b0 && k < 20) begin
            @(posedge clock); #1; k++;
        end
        checks++;
        if (k != 10) begin
            errors++;
            $display("FAIL hold_len: core_reset high %0d cycles, expected 10", k);
        end
        cur_c = 0;
    endtask

    task automatic run_cycles(input int n, input bit rnd_ack, input bit rnd_wr,
                              input int ack_c, input logic [3:0] ack_m);
        logic [3:0] exp, ack;
        int ch, p;
        bit l;
        for (int j = 0; j < n; j++) begin
            model_expect(cur_c, exp);
            checks++;
            if (irq !== exp) begin
                errors++;
                $display("FAIL irq@%0d: got %b, expected %b", cur_c, irq, exp);
            end
            checks++;
            if (cycle_count !== 32'(cur_c)) begin
                errors++;
                $display("FAIL cycle_count@%0d: got %0d, expected %0d", cur_c, cycle_count, cur_c);
            end
            ack = rnd_ack ? 4'($urandom) : ((cur_c == ack_c) ? ack_m : 4'b0000);
            irq_ack = ack;
            model_ack(cur_c, ack);
            cfg_we = 1'b0;
            if (rnd_wr && $urandom_range(0, 15) == 0) begin
                ch = $urandom_range(0, 3); p = $urandom_range(0, 9); l = 1'($urandom_range(0, 1));
                cfg_we = 1'b1; cfg_sel = 2'(ch); cfg_period = 16'(p); cfg_level = l;
                model_cfg(ch, p, l, cur_c + 1);
            end
            @(posedge clock); #1;
            cur_c++;
        end
        irq_ack = '0;
        cfg_we  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; trap = 1'b0; irq_ack = '0; cfg_we = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (core_reset !== 1'b1 || irq !== 4'b0 || done !== 1'b0 || status !== 2'b00 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_vals: core_reset=%b irq=%b done=%b status=%b cycle_count=%0d, expected 1 0000 0 00 0",
                     core_reset, irq, done, status, cycle_count);
        end
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clock); #1;
            checks++;
            if (core_reset !== (k < 10)) begin
                errors++;
                $display("FAIL hold_edge%0d: core_reset=%b, expected %b", k, core_reset, (k < 10));
            end
        end
    endtask

    task automatic test_pulse();
        start_run({16'd0, 16'd0, 16'd5, 16'd0}, 4'b0000);
        run_cycles(21, 1'b0, 1'b0, -1, 4'b0000);
    endtask

    task automatic test_level();
        start_run({16'd4, 16'd0, 16'd0, 16'd0}, 4'b1000);
        run_cycles(16, 1'b0, 1'b0, 7, 4'b1000);
    endtask

    task automatic test_random_irq();
        logic [3:0][15:0] per;
        logic [3:0]       lvl;
        for (int r = 0; r < 4; r++) begin
            for (int ch = 0; ch < 4; ch++) per[ch] = 16'($urandom_range(0, 9));
            lvl = 4'($urandom);
            start_run(per, lvl);
            run_cycles(80, 1'b1, 1'b1, -1, 4'b0000);
        end
    endtask

    task automatic test_trap();
        logic [3:0][15:0] per;
        int n;
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                start_run({16'd0, 16'd0, 16'd0, 16'd7}, 4'b0001);
                n = 300;
                run_cycles(n, 1'b0, 1'b0, -1, 4'b0000);
            end else begin
                for (int ch = 0; ch < 4; ch++) per[ch] = 16'($urandom_range(1, 9));
                start_run(per, 4'($urandom));
                n = $urandom_range(20, 150);
                run_cycles(n, 1'b1, 1'b1, -1, 4'b0000);
            end
            trap = 1'b1;
            @(posedge clock); #1;
            trap = 1'b0;
            checks++;
            if (done !== 1'b1 || status !== 2'b01 || cycle_count !== 32'(n) || irq !== 4'b0 || core_reset !== 1'b1) begin
                errors++;
                $display("FAIL trap_end: done=%b status=%b cycle_count=%0d irq=%b core_reset=%b, expected 1 01 %0d 0000 1",
                         done, status, cycle_count, irq, core_reset, n);
            end
            repeat (5) @(posedge clock);
            #1;
            checks++;
            if (done !== 1'b1 || status !== 2'b01 || cycle_count !== 32'(n) || irq !== 4'b0) begin
                errors++;
                $display("FAIL trap_frozen: done=%b status=%b cycle_count=%0d irq=%b, expected 1 01 %0d 0000",
                         done, status, cycle_count, irq, n);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        start_run({16'd0, 16'd0, 16'd0, 16'd0}, 4'b0000);
        n = 0;
        while (done !== 1'b1 && n < 10100) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (n != 10000 || status !== 2'b10 || cycle_count !== 32'd9999) begin
            errors++;
            $display("FAIL timeout: done after %0d cycles status=%b cycle_count=%0d, expected 10000 10 9999",
                     n, status, cycle_count);
        end
        trap = 1'b1;
        repeat (3) @(posedge clock);
        #1 trap = 1'b0;
        checks++;
        if (status !== 2'b10 || cycle_count !== 32'd9999 || done !== 1'b1) begin
            errors++;
            $display("FAIL trap_in_done: status=%b cycle_count=%0d done=%b, expected 10 9999 1",
                     status, cycle_count, done);
        end
    endtask

    task automatic test_trap_timeout();
        int k;
        reset_b = 1'b0; trap_b = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_b = 1'b1;
        k = 0;
        while (core_reset_b !== 1'b0 && k < 20) begin
            @(posedge clock); #1; k++;
        end
        repeat (49) @(posedge clock);
        #1;
        checks++;
        if (done_b !== 1'b0 || cycle_count_b !== 32'd49) begin
            errors++;
            $display("FAIL tt_pre: done=%b cycle_count=%0d, expected 0 49", done_b, cycle_count_b);
        end
        trap_b = 1'b1;
        @(posedge clock); #1;
        trap_b = 1'b0;
        checks++;
        if (done_b !== 1'b1 || status_b !== 2'b01 || cycle_count_b !== 32'd49) begin
            errors++;
            $display("FAIL trap_vs_timeout: done=%b status=%b cycle_count=%0d, expected 1 01 49",
                     done_b, status_b, cycle_count_b);
        end
    endtask

    task automatic test_reset_midrun();
        int k;
        start_run({16'd0, 16'd3, 16'd1, 16'd0}, 4'b0100);
        run_cycles(20, 1'b0, 1'b0, -1, 4'b0000);
        checks++;
        if (irq === 4'b0000) begin
            errors++;
            $display("FAIL midrun_active: irq=%b, expected nonzero", irq);
        end
        reset = 1'b0;
        #2;
        checks++;
        if (core_reset !== 1'b1 || irq !== 4'b0 || done !== 1'b0 || status !== 2'b00 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: core_reset=%b irq=%b done=%b status=%b cycle_count=%0d, expected 1 0000 0 00 0",
                     core_reset, irq, done, status, cycle_count);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        trap  = 1'b1;
        k = 0;
        while (core_reset !== 1'b0 && k < 20) begin
            @(posedge clock); #1; k++;
            if (k == 5) trap = 1'b0;
        end
        trap = 1'b0;
        checks++;
        if (k != 10 || done !== 1'b0) begin
            errors++;
            $display("FAIL rehold: hold %0d cycles done=%b, expected 10 0", k, done);
        end
        for (int ch = 0; ch < 4; ch++) model_cfg(ch, 0, 1'b0, 0);
        cur_c = 0;
        run_cycles(5, 1'b0, 1'b0, -1, 4'b0000);
        checks++;
        if (done !== 1'b0 || status !== 2'b00) begin
            errors++;
            $display("FAIL hold_trap_ignored: done=%b status=%b, expected 0 00", done, status);
        end
    endtask

    initial begin
        reset = 1'b0; reset_b = 1'b0; trap = 1'b0; trap_b = 1'b0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_period = '0; cfg_level = 1'b0; irq_ack = '0;
        test_reset();
        test_pulse();
        test_level();
        test_random_irq();
        test_trap();
        test_trap_timeout();
        test_reset_midrun();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
